systolic_output_collector: RTL and testbench

//  Downstream stage of tt_um_systolic_array: consumes column outputs data_out1..5 (16b each).

---
 rtl/systolic_output_collector_pkg.sv | 10 +
 rtl/systolic_output_collector_if.sv | 13 +
 rtl/systolic_result_fifo.sv | 52 +++++
 rtl/systolic_output_collector.sv | 108 ++++++++++
 tb/tb_systolic_output_collector.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/systolic_output_collector_pkg.sv
// Shared constants and word types for the systolic array output path.
package systolic_output_collector_pkg;
    localparam int NUM_COLS = 5;
    localparam int DATA_W   = 8;
    localparam int PSUM_W   = 16;
    localparam int WORD_W   = NUM_COLS * PSUM_W;

    typedef logic [PSUM_W-1:0] psum_t;
    typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/systolic_output_collector_if.sv
// Result stream from the collector to the host.
// Handshake: a word transfers in any cycle where valid && ready; valid and data
// hold steady until that transfer, and ready may change freely at any time.
interface systolic_output_collector_if;
    import systolic_output_collector_pkg::*;

    logic  valid;
    logic  ready;
    word_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/systolic_result_fifo.sv
// Result word FIFO with wrap-bit pointers; a push while full is dropped unless
// a pop frees the slot in the same cycle.
module systolic_result_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             empty_o,
    output logic             drop_o,
    output logic [WIDTH-1:0] head_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty_o  = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full || do_pop);
        drop_o   = push_i && full && !do_pop;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        head_o   = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: head_o is forced to zero whenever empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end
endmodule

// File: rtl/systolic_output_collector.sv
// Deskews the five systolic column outputs into one word and buffers it for the host.
// Optional DROP_CNT_EN adds an 8-bit saturating count of words dropped on a full FIFO.
module systolic_output_collector
    import systolic_output_collector_pkg::*;
#(
    parameter int ARRAY_LAT  = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ena,
    input  logic                        in_valid,
    input  psum_t                       col_in1,
    input  psum_t                       col_in2,
    input  psum_t                       col_in3,
    input  psum_t                       col_in4,
    input  psum_t                       col_in5,
    systolic_output_collector_if.master out_if,
    output logic                        overflow
`ifdef DROP_CNT_EN
    ,
    output logic [7:0]                  drop_cnt
`endif
);
    localparam int PIPE_D = ARRAY_LAT + 4;

    logic [PIPE_D-1:0] vpipe_q, vpipe_d;
    psum_t             d1_q [4];
    psum_t             d2_q [3];
    psum_t             d3_q [2];
    psum_t             d4_q;
    word_t             aligned;
    logic              push;
    logic              pop;
    logic              empty;
    logic              drop;

    always_comb begin
        vpipe_d = {vpipe_q[PIPE_D-2:0], in_valid & ena};
        // Column j lags column 1 by j-1 cycles, so earlier columns wait longer.
        aligned = {col_in5, d4_q, d3_q[1], d2_q[2], d1_q[3]};
        push    = vpipe_q[PIPE_D-1];
        pop     = out_if.valid && out_if.ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vpipe_q <= '0;
            for (int i = 0; i < 4; i++) d1_q[i] <= '0;
            for (int i = 0; i < 3; i++) d2_q[i] <= '0;
            for (int i = 0; i < 2; i++) d3_q[i] <= '0;
            d4_q <= '0;
        end else begin
            vpipe_q <= vpipe_d;
            d1_q[0] <= col_in1;
            for (int i = 1; i < 4; i++) d1_q[i] <= d1_q[i-1];
            d2_q[0] <= col_in2;
            for (int i = 1; i < 3; i++) d2_q[i] <= d2_q[i-1];
            d3_q[0] <= col_in3;
            d3_q[1] <= d3_q[0];
            d4_q    <= col_in4;
        end
    end

    systolic_result_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push),
        .push_data_i (aligned),
        .pop_i       (pop),
        .empty_o     (empty),
        .drop_o      (drop),
        .head_o      (out_if.data)
    );

    assign out_if.valid = !empty;

`ifdef DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
    assign overflow = (drop_cnt_q != 8'd0);
`else
    logic overflow_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    overflow_q <= 1'b0;
        else if (drop) overflow_q <= 1'b1;
    end

    assign overflow = overflow_q;
`endif
endmodule

// File: tb/tb_systolic_output_collector.sv
// Bench for systolic_output_collector: emulates the array's skewed column timing,
// predicts accepted words in a queue and checks every cycle against the DUT.
module tb_systolic_output_collector;
    import systolic_output_collector_pkg::*;

    localparam int LAT   = 5;
    localparam int DEPTH = 4;

    logic  clk = 1'b0;
    logic  rst_n;
    logic  ena;
    logic  in_valid;
    psum_t col_drv [5];
    logic  overflow;
`ifdef DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    systolic_output_collector_if out_if();

    systolic_output_collector #(
        .ARRAY_LAT  (LAT),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .in_valid (in_valid),
        .col_in1  (col_drv[0]),
        .col_in2  (col_drv[1]),
        .col_in3  (col_drv[2]),
        .col_in4  (col_drv[3]),
        .col_in5  (col_drv[4]),
        .out_if   (out_if),
        .overflow (overflow)
`ifdef DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Model state: accepted words awaiting the host, and drop count.
    word_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    cyc     = 0;
    int    m_drops = 0;
    bit    chk_on  = 0;

    // Future schedule of array column outputs and word arrivals, by cycle mod 64.
    psum_t col_val  [5][64];
    bit    col_has  [5][64];
    word_t arr_word [64];
    bit    arr_flag [64];

    task automatic chk(input string name, input logic [WORD_W-1:0] act, input logic [WORD_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, WORD_W'(out_if.valid), '0);
        chk({tag, "_data"}, out_if.data, '0);
        chk({tag, "_overflow"}, WORD_W'(overflow), '0);
`ifdef DROP_CNT_EN
        chk({tag, "_drop_cnt"}, WORD_W'(drop_cnt), '0);
`endif
    endtask

    // Admission: a word arriving while the host-side queue holds DEPTH words is lost.
    always @(posedge clk) begin
        int s;
        s = cyc % 64;
        if (rst_n && arr_flag[s]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(arr_word[s]);
            else                      m_drops++;
        end
        arr_flag[s] = 1'b0;
        cyc++;
    end

    // Monitor: compares the presented word and flags, retires words on handshake.
    always @(negedge clk) begin
        bit exp_v;
        if (chk_on) begin
            exp_v = (exp_q.size() != 0);
            chk("out_valid", WORD_W'(out_if.valid), WORD_W'(exp_v));
            chk("out_data", out_if.data, exp_v ? exp_q[0] : '0);
            chk("overflow", WORD_W'(overflow), WORD_W'(m_drops != 0));
`ifdef DROP_CNT_EN
            chk("drop_cnt", WORD_W'(drop_cnt), WORD_W'((m_drops > 255) ? 255 : m_drops));
`endif
            if (exp_v && out_if.ready) void'(exp_q.pop_front());
        end
    end

    // One cycle of stimulus; column j of an injected vector shows up LAT+j-1 cycles later.
    task automatic drive(input bit iv, input bit en, input bit rdy, input word_t w);
        int s;
        in_valid     = iv;
        ena          = en;
        out_if.ready = rdy;
        s = cyc % 64;
        for (int j = 0; j < 5; j++) begin
            col_drv[j]    = col_has[j][s] ? col_val[j][s] : psum_t'($urandom);
            col_has[j][s] = 1'b0;
        end
        if (iv && en) begin
            for (int j = 0; j < 5; j++) begin
                col_val[j][(cyc + LAT + j) % 64] = w[16*j +: 16];
                col_has[j][(cyc + LAT + j) % 64] = 1'b1;
            end
            arr_word[(cyc + LAT + 4) % 64] = w;
            arr_flag[(cyc + LAT + 4) % 64] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b1, rdy, '0);
    endtask

    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        ena      = 1'b0;
        exp_q.delete();
        m_drops = 0;
        for (int i = 0; i < 64; i++) arr_flag[i] = 1'b0;
        #1;
        chk_zero_outputs(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // All-k input vector against weights 1..5 gives 15*k in every column.
    function automatic word_t ones_word(input int k);
        psum_t c;
        c = psum_t'(15 * k);
        return {c, c, c, c, c};
    endfunction

    function automatic word_t rand_word();
        return {$urandom(), $urandom(), 16'($urandom())};
    endfunction

    initial begin
        rst_n        = 1'b0;
        ena          = 1'b0;
        in_valid     = 1'b0;
        out_if.ready = 1'b0;
        for (int j = 0; j < 5; j++) col_drv[j] = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_zero_outputs("reset");
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Single vector, host always ready.
        drive(1'b1, 1'b1, 1'b1, ones_word(1));
        idle(20, 1'b1);

        // Three back-to-back vectors.
        for (int k = 1; k <= 3; k++) drive(1'b1, 1'b1, 1'b1, ones_word(k));
        idle(20, 1'b1);

        // Host stalled, five vectors into a four-deep FIFO, then drain.
        for (int k = 1; k <= 5; k++) drive(1'b1, 1'b1, 1'b0, ones_word(k));
        idle(15, 1'b0);
        idle(12, 1'b1);
        do_reset("reset_after_overflow");

        // Full FIFO receiving a word in the same cycle the host pops.
        for (int k = 1; k <= 4; k++) drive(1'b1, 1'b1, 1'b0, ones_word(k));
        idle(10, 1'b0);
        drive(1'b1, 1'b1, 1'b0, ones_word(9));
        idle(8, 1'b0);
        idle(15, 1'b1);

        // Disabled block ignores in_valid.
        for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, 1'b1, rand_word());
        idle(15, 1'b1);

        // Reset with two vectors in flight.
        drive(1'b1, 1'b1, 1'b1, ones_word(2));
        drive(1'b1, 1'b1, 1'b1, ones_word(3));
        idle(3, 1'b1);
        do_reset("reset_in_flight");
        idle(20, 1'b1);

        // Randomized traffic with random enable and back-pressure.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1) == 1, $urandom_range(0, 9) != 0,
                  $urandom_range(0, 9) < 6, rand_word());
        end
        idle(25, 1'b1);
        chk("drained", WORD_W'(exp_q.size()), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
